// File: rtl/winograd_result_packer_pkg.sv
// winograd_pkg: line geometry, result word layout and FSM states shared with the Winograd accelerator.
package winograd_pkg;
    localparam int LINE_WIDTH     = 512;
    localparam int TILES_PER_LINE = 4;
    localparam int TILE_DIM       = 2;
    localparam int ENTRY_WORDS    = 16;
    localparam int TILE_BITS      = LINE_WIDTH / TILES_PER_LINE;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    function automatic int word_off(input int i, input int j);
        return 128 * i + 32 * j;
    endfunction
endpackage

// File: rtl/winograd_result_packer_if.sv
// winograd_result_packer_if: result FIFO read port and packed-line write port of the packer.
interface winograd_result_packer_if;
    import winograd_pkg::*;
    logic [LINE_WIDTH-1:0] res_fifo_dout;
    logic                  res_fifo_empty;
    logic                  res_fifo_re;
    logic [LINE_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  wr_last;

    modport master(
        input  res_fifo_dout, res_fifo_empty, wr_ready,
        output res_fifo_re, wr_data, wr_valid, wr_last
    );
    modport slave(
        output res_fifo_dout, res_fifo_empty, wr_ready,
        input  res_fifo_re, wr_data, wr_valid, wr_last
    );
endinterface

// File: rtl/winograd_result_packer.sv
// winograd_result_packer: packs the 2x2 tile of each result FIFO entry, four per 512-bit line, onto a valid/ready write port.
module winograd_result_packer
    import winograd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_WIDTH-1:0]     ctx_length,
    winograd_result_packer_if.master bus,
    output logic                     busy,
    output logic                     done
);
    localparam int TW = 4 * DATA_WIDTH;

    state_t                state;
    logic [LEN_WIDTH-1:0]  len, req_cnt, rcv_cnt;
    logic [2:0]            pack_cnt;
    logic                  rd_pending, out_free, xfer;
    logic [LINE_WIDTH-1:0] pack_line;
    logic [TW-1:0]         tile;
    logic                  unused_dout;

    assign tile = {bus.res_fifo_dout[word_off(1, 1) +: DATA_WIDTH], bus.res_fifo_dout[word_off(1, 0) +: DATA_WIDTH],
                   bus.res_fifo_dout[word_off(0, 1) +: DATA_WIDTH], bus.res_fifo_dout[word_off(0, 0) +: DATA_WIDTH]};
    assign unused_dout = ^bus.res_fifo_dout;
    assign busy = state != IDLE;
    assign out_free = !bus.wr_valid || bus.wr_ready;
    // at pack_cnt==4 a read is only safe when the line leaves on this same edge
    assign bus.res_fifo_re = state == RUN && !bus.res_fifo_empty && req_cnt < len &&
                             (pack_cnt + 3'(rd_pending) < 3'd4 || (pack_cnt == 3'd4 && !rd_pending && out_free));
    assign xfer = out_free && ((state == RUN && pack_cnt == 3'd4) || (state == FLUSH && pack_cnt != 3'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            len          <= '0;
            req_cnt      <= '0;
            rcv_cnt      <= '0;
            pack_cnt     <= '0;
            rd_pending   <= 1'b0;
            pack_line    <= '0;
            bus.wr_data  <= '0;
            bus.wr_valid <= 1'b0;
            bus.wr_last  <= 1'b0;
            done         <= 1'b0;
        end else begin
            done       <= state == DONE;
            rd_pending <= bus.res_fifo_re;
            if (bus.res_fifo_re) req_cnt <= req_cnt + LEN_WIDTH'(1);
            if (rd_pending) rcv_cnt <= rcv_cnt + LEN_WIDTH'(1);
            if (xfer) begin
                pack_line    <= LINE_WIDTH'(rd_pending ? tile : '0);
                pack_cnt     <= 3'(rd_pending);
                bus.wr_data  <= pack_line;
                bus.wr_valid <= 1'b1;
                bus.wr_last  <= state == FLUSH || rcv_cnt == len;
            end else begin
                if (rd_pending) begin
                    pack_line[TW * int'(pack_cnt[1:0]) +: TW] <= tile;
                    pack_cnt <= pack_cnt + 3'd1;
                end
                if (bus.wr_ready) begin
                    bus.wr_valid <= 1'b0;
                    bus.wr_last  <= 1'b0;
                end
            end
            if (state == IDLE && start) begin
                len        <= ctx_length;
                req_cnt    <= '0;
                rcv_cnt    <= '0;
                pack_cnt   <= '0;
                rd_pending <= 1'b0;
                pack_line  <= '0;
                state      <= ctx_length == '0 ? DONE : RUN;
            end else if (state == RUN && rcv_cnt == len && !rd_pending) begin
                state <= FLUSH;
            end else if (state == FLUSH && bus.wr_valid && bus.wr_ready && bus.wr_last) begin
                state <= DONE;
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_winograd_result_packer.sv
// tb_winograd_result_packer: directed and randomized contexts against a queue-based packing model.
module tb_winograd_result_packer;
    logic        clk = 1'b0;
    logic        reset, start, busy, done;
    logic [31:0] ctx_length;
    winograd_result_packer_if bus();

    winograd_result_packer dut (
        .clk(clk), .reset(reset), .start(start), .ctx_length(ctx_length),
        .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int reads, re_bad, unstable, done_cnt, acc_cyc, done_cyc;
    bit re_s = 1'b0, gap = 1'b0, rdy = 1'b1, prev_stall = 1'b0;
    logic [511:0] prev_data;
    logic [511:0] fq[$];
    logic [511:0] exp_q[$];
    logic [511:0] got[$];
    bit got_last[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // one clock: FIFO pop after the edge, inputs at negedge, then sample outputs
    task automatic cycle();
        @(posedge clk);
        if (re_s && fq.size() > 0) bus.res_fifo_dout <= fq.pop_front();
        @(negedge clk);
        bus.res_fifo_empty = gap || fq.size() == 0;
        bus.wr_ready = rdy;
        #1;
        re_s = bus.res_fifo_re;
        if (re_s) reads++;
        if (re_s && bus.res_fifo_empty) re_bad++;
        if (prev_stall && (bus.wr_valid !== 1'b1 || bus.wr_data !== prev_data)) unstable++;
        prev_stall = bus.wr_valid && !bus.wr_ready;
        prev_data = bus.wr_data;
        if (bus.wr_valid && bus.wr_ready) begin
            got.push_back(bus.wr_data);
            got_last.push_back(bus.wr_last);
            acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic load(input int n, input bit pat);
        logic [511:0] e, l;
        logic [31:0] w[4][4];
        fq.delete();
        exp_q.delete();
        l = '0;
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    w[i][j] = pat ? 32'((t << 4) | (4 * i + j)) : $urandom;
                    e[32 * (4 * i + j) +: 32] = w[i][j];
                end
            l[128 * (t % 4) +: 128] = {w[1][1], w[1][0], w[0][1], w[0][0]};
            fq.push_back(e);
            if (t % 4 == 3 || t == n - 1) begin
                exp_q.push_back(l);
                l = '0;
            end
        end
    endtask

    task automatic run_ctx(input string tag, input int n, input bit pat, input bit rnd,
                           input int stall_len, input int gap_at, input int gap_len);
        int s_cyc, stall_left, stall_r0, stall_reads, nl;
        bit stall_started, measured;
        load(n, pat);
        got.delete();
        got_last.delete();
        reads = 0; re_bad = 0; unstable = 0; done_cnt = 0; acc_cyc = -1; done_cyc = -1;
        stall_left = 0; stall_r0 = 0; stall_reads = 0; stall_started = 0; measured = 0;
        ctx_length = n;
        start = 1'b1;
        s_cyc = cyc - 1;
        cycle();
        start = 1'b0;
        chk({tag, " busy"}, busy, 1);
        for (int k = 0; k < 800 && done_cnt == 0; k++) begin
            if (stall_len > 0 && !stall_started && got.size() > 0) begin
                stall_started = 1;
                stall_left = stall_len;
                stall_r0 = reads;
            end
            if (stall_started && stall_left == 0 && !measured) begin
                measured = 1;
                stall_reads = reads - stall_r0;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : stall_left == 0;
            if (stall_left > 0) stall_left--;
            gap = gap_len > 0 && cyc - s_cyc >= gap_at && cyc - s_cyc < gap_at + gap_len;
            cycle();
        end
        rdy = 1'b1;
        gap = 1'b0;
        repeat (3) cycle();
        nl = exp_q.size();
        chk({tag, " lines"}, got.size(), nl);
        for (int l = 0; l < nl; l++)
            if (l < got.size()) begin
                chk($sformatf("%s data%0d", tag, l), got[l], exp_q[l]);
                chk($sformatf("%s last%0d", tag, l), got_last[l], l == nl - 1);
            end
        chk({tag, " reads"}, reads, n);
        chk({tag, " re_when_empty"}, re_bad, 0);
        chk({tag, " stable"}, unstable, 0);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_cyc, n == 0 ? s_cyc + 2 : acc_cyc + 2);
        chk({tag, " idle_busy"}, busy, 0);
        if (stall_len > 0) begin
            chk({tag, " stall_seen"}, measured, 1);
            chk({tag, " stall_reads_le8"}, stall_reads <= 8, 1);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ctx_length = '0;
        bus.wr_ready = 1'b1;
        bus.res_fifo_empty = 1'b1;
        bus.res_fifo_dout = '0;
        repeat (3) cycle();
        chk("reset re", bus.res_fifo_re, 0);
        chk("reset wr_valid", bus.wr_valid, 0);
        chk("reset wr_last", bus.wr_last, 0);
        chk("reset wr_data", bus.wr_data, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        reset = 1'b1;
        cycle();

        run_ctx("len4", 4, 1, 0, 0, 0, 0);
        run_ctx("len6", 6, 1, 0, 0, 0, 0);
        run_ctx("len0", 0, 0, 0, 0, 0, 0);
        run_ctx("len16_stall", 16, 0, 0, 20, 0, 0);
        run_ctx("len8_gap", 8, 0, 0, 0, 3, 10);
        for (int r = 0; r < 4; r++)
            run_ctx($sformatf("rnd%0d", r), $urandom_range(1, 13), 0, 1, 0, 0, 0);

        load(8, 0);
        ctx_length = 8;
        start = 1'b1;
        rdy = 1'b0;
        cycle();
        start = 1'b0;
        repeat (14) cycle();
        chk("abort pre wr_valid", bus.wr_valid, 1);
        reset = 1'b0;
        #1;
        chk("abort wr_valid", bus.wr_valid, 0);
        chk("abort re", bus.res_fifo_re, 0);
        chk("abort wr_last", bus.wr_last, 0);
        chk("abort wr_data", bus.wr_data, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        cycle();
        reset = 1'b1;
        rdy = 1'b1;
        prev_stall = 1'b0;
        cycle();
        run_ctx("after_abort", 4, 1, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/winograd_result_packer.md
# winograd_result_packer

Drain-side companion of the Winograd tile accelerator. It reads the accelerator's 512-bit result FIFO, where each entry carries one 2x2 output tile. It extracts the four valid 32-bit results from each entry and packs four tiles per dense 512-bit line. Lines go to the memory write path over a valid/ready handshake, and the last partial line is flushed at context end.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one result word; fixed at 32 for the 512-bit packing.
- LEN_WIDTH, 32, width of the tile-count input.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse in IDLE that begins a context.
- ctx_length  in  LEN_WIDTH  number of result tiles in the context; sampled on start.
- res_fifo_dout  in  512  result FIFO read data; valid the cycle after res_fifo_re.
- res_fifo_empty  in  1  result FIFO empty.
- res_fifo_re  out  1  result FIFO read enable.
- wr_data  out  512  packed line.
- wr_valid  out  1  wr_data valid; held until accepted.
- wr_ready  in  1  sink accepts the line when wr_valid && wr_ready.
- wr_last  out  1  marks the final line of the context; qualified by wr_valid.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when the context completes.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: on start, latch len=ctx_length and clear req_cnt, rcv_cnt, pack_cnt and rd_pending. Go to RUN, or to DONE if len==0; len==0 produces no write.
- Tile extraction: word(i,j) = res_fifo_dout[128i+32j+31 : 128i+32j]. The tile is y00=word(0,0), y01=word(0,1), y10=word(1,0), y11=word(1,1). Words at i,j >= 2 are ignored.
- Packing: tile k (0..3) of a line occupies bits [128k+127:128k]:
  - y00 at [128k+31:128k]
  - y01 at +32
  - y10 at +64
  - y11 at +96
- res_fifo_re = RUN && !res_fifo_empty && req_cnt<len && (pack_cnt+rd_pending<4 || (pack_cnt==4 && !rd_pending && out_free)), where out_free = !wr_valid || wr_ready.
- rd_pending is registered res_fifo_re. When rd_pending is high, the tile is captured into slot pack_cnt (or slot 0 of a fresh line if the line transfers that edge), and rcv_cnt increments.
- Transfer: when pack_cnt==4 and out_free, the pack line moves to the output register. wr_valid is set and pack_cnt is cleared.
- wr_last is set on the transfer whose line contains tile number len-1.
- RUN -> FLUSH when rcv_cnt==len and no read is pending.
- FLUSH: if 0 < pack_cnt < 4, the partial line transfers once out_free, with unused slots zero and wr_last=1. Then go to DONE after the last line is accepted (wr_valid && wr_ready && wr_last).
- DONE: pulse done for one cycle, then go to IDLE.
- start outside IDLE is ignored. The block never reads more than len entries.

## Timing
- Reset values: res_fifo_re=0, wr_valid=0, wr_last=0, wr_data=0, busy=0, done=0; FSM in IDLE; all counters 0.
- Reset asserted mid-context aborts immediately to these values. Unread FIFO entries and an unaccepted line are discarded.
- start sampled at edge T: busy high and res_fifo_re possible from cycle T+1.
- Tile latency: the 4th tile of a line is read in cycle c, captured at the end of c+1, transfers at the end of c+2, and wr_valid is high in c+3.
- Throughput: with no backpressure, one line per 5 cycles, because reads stall one cycle per line at pack_cnt=3 with rd_pending=1.
- wr_valid and wr_data are stable while wr_valid && !wr_ready. wr_valid drops the cycle after acceptance unless a new line transfers on the same edge.
- Backpressure: reads stop while the pack line is full and wr_valid is stalled. No tile is lost or overwritten.
- FIFO empty: no re is issued; pipeline state holds.
- done is asserted exactly one cycle after the final acceptance edge.

## Structure
- Shared package winograd_pkg holds:
  - LINE_WIDTH=512
  - TILES_PER_LINE=4
  - the result word offset function (128i+32j)
  - the FSM state enum
  - shared constants with the accelerator
- No sub-module: single flat module. The FIFO stays external in the accelerator wrapper.

## Test plan
- len=4, FIFO pre-filled with tiles whose words equal (tile<<4)|(4i+j), wr_ready=1 -> exactly one line, wr_last=1, with slot k words {k<<4|0, k<<4|1, k<<4|4, k<<4|5}; done one cycle after acceptance.
- len=6 -> two lines. The second line has slots 0-1 holding tiles 4-5 and slots 2-3 zero, with wr_last only on the second line.
- len=0 -> no res_fifo_re, no wr_valid, done pulse two cycles after start.
- len=16 with wr_ready held low for 20 cycles after the first line -> wr_data stable throughout, at most 4+4 tiles read before the stall releases, and all 4 lines correct and in order.
- FIFO empty for 10 cycles mid-line, len=8 -> res_fifo_re stays low while empty and the output matches the no-gap reference.
- Assert reset while a line waits on wr_ready -> all outputs 0 the next cycle. A new start with len=4 then produces a correct single line.
